shiftx_ift: RTL and testbench
=============================

Name: shiftx_ift

Overview:
- Tainted, registered model of the logical right-shift-with-undefined-fill cell (Y = A >> B) for information-flow tracking (IFT) netlists.
- Data path computes the shifted value. A parallel 32-bit taint-tag path reports which input labels can influence Y.
- Instantiated as primitive m_0 in IFT-instrumented cell netlists, one instance per shift cell.

Parameters:
- A_W, 2, width of data operand A.
- B_W, 2, width of unsigned shift amount B.
- Y_W, 2, width of result Y.
- TAG_W, 32, width of every taint-tag vector (one bit per label source).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- A  input  A_W  data operand.
- A_t  input  TAG_W  taint tag of A (whole-signal label set).
- B  input  B_W  unsigned shift amount.
- B_t  input  TAG_W  taint tag of B.
- Y  output  Y_W  shifted result (registered).
- Y_t  output  TAG_W  taint tag of Y (registered).

Behaviour:
- Reset: rst_n low asynchronously forces Y = 0 and Y_t = 0. Both stay 0 until the first rising clk after rst_n deasserts.
- Latency: exactly 1 cycle. Inputs are sampled on the rising clk edge and appear on Y/Y_t after that edge. No handshake; a new input is accepted every cycle.
- Data: for each bit i in 0..Y_W-1, Y[i] = A[i+B] if i+B < A_W, else 0. Out-of-range bits are driven to 0, never X.
  - B is unsigned. Shift amounts >= A_W give Y = 0.
  - Default widths: B=0 gives Y=A. B=1 gives Y={0,A[1]}. B=2 or 3 gives Y=00.
- Taint, precise rule:
  - B always controls Y, so Y_t always includes B_t.
  - A_t is included only if at least one in-range A bit is selected, i.e. B < A_W.
  - Therefore Y_t = B_t | (B < A_W ? A_t : 0).
- Taint is a bitwise OR of label sets. There is no per-bit taint and no declassification.
- Taint is independent of the data value of A: A = 00 still propagates A_t when B < A_W.
- Width rule: comparisons use B zero-extended to max(B_W, clog2(A_W)+1) bits, so large B never wraps.
- Simultaneous reset and clock: reset wins.
- Reset mid-stream: the output clears immediately. The first post-reset edge loads the current inputs.

Decomposition:
- Shared package ift_pkg holds the TAG_W default constant, a tag_t typedef (logic [TAG_W-1:0]), and a function tag_or(a, b).
- One natural sub-module, ift_shiftx_comb: purely combinational data-plus-taint computation.
  - The top shiftx_ift wraps it with the output register and async reset.
- Elaboration check: Y_W >= 1, A_W >= 1, B_W >= 1, TAG_W >= 1.

Test Plan:
- Reset: hold rst_n=0 with A=11, B=00, A_t=32'hFFFF_FFFF, B_t=32'h1 -> Y=00, Y_t=0. After release plus 1 clk -> Y=11, Y_t=32'hFFFF_FFFF.
- Sweep A over 00..11 and B over 00..11 with A_t=32'h0000_00F0, B_t=32'h0000_000F. Responses one cycle later:
  - B=0 -> Y=A, Y_t=32'h0000_00FF.
  - B=1 -> Y={0,A[1]}, Y_t=32'h0000_00FF.
  - B=2 or 3 -> Y=00, Y_t=32'h0000_000F.
- Taint only on A (A_t=32'h8000_0001, B_t=0), A=10:
  - B=01 -> Y=01, Y_t=32'h8000_0001.
  - B=10 -> Y=00, Y_t=0.
- Taint only on B (A_t=0, B_t=32'h0001_0000), any A, any B -> Y_t=32'h0001_0000 every cycle.
- Zero data with taint: A=00, B=00, A_t=32'h5, B_t=0 -> Y=00, Y_t=32'h5.
- Async reset mid-stream: assert rst_n low between clock edges while Y=11 -> Y and Y_t become 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/ift_pkg.sv
// Shared definitions for information-flow-tracking (IFT) primitive cells.
package ift_pkg;

    // Default number of taint labels tracked per signal
    localparam int IFT_TAG_W = 32;

    // One bit per label source; a set bit means that label may influence the value
    typedef logic [IFT_TAG_W-1:0] tag_t;

    // Union of two label sets
    function automatic tag_t tag_or(input tag_t a, input tag_t b);
        return a | b;
    endfunction

endpackage

// File: rtl/ift_shiftx_comb.sv
// Combinational core of the tainted logical right shift: data result plus
// the label set of everything that can influence that result.
module ift_shiftx_comb
    import ift_pkg::*;
#(
    parameter int A_W   = 2,
    parameter int B_W   = 2,
    parameter int Y_W   = 2,
    parameter int TAG_W = IFT_TAG_W
) (
    input  logic [A_W-1:0]   a,
    input  logic [TAG_W-1:0] a_t,
    input  logic [B_W-1:0]   b,
    input  logic [TAG_W-1:0] b_t,
    output logic [Y_W-1:0]   y,
    output logic [TAG_W-1:0] y_t
);

    // B is compared in a width wide enough to hold A_W, so large shift
    // amounts never wrap back into range.
    localparam int A_CNT_W = $clog2(A_W) + 1;
    localparam int CMP_W   = (B_W > A_CNT_W) ? B_W : A_CNT_W;
    localparam int PAD_W   = A_W + Y_W;

    logic [CMP_W-1:0] b_ext;
    logic             a_selected;
    logic [PAD_W-1:0] padded;
    logic [PAD_W-1:0] shifted;

    // A is zero-extended above its top bit so result bits past the end of A
    // read 0; an over-long shift empties the vector entirely.
    always_comb begin
        b_ext      = CMP_W'(b);
        a_selected = (b_ext < CMP_W'(A_W));
        padded     = {{Y_W{1'b0}}, a};
        shifted    = padded >> b;
        y          = shifted[Y_W-1:0];
    end

    // B always steers the result; A's labels reach Y only when some A bit
    // is actually selected, regardless of A's data value.
    always_comb begin
        y_t = b_t | (a_selected ? a_t : {TAG_W{1'b0}});
    end

endmodule

// File: rtl/shiftx_ift.sv
// Registered tainted logical right shift (Y = A >> B) for IFT netlists.
// One-cycle latency, a new operand accepted every clock.
module shiftx_ift
    import ift_pkg::*;
#(
    parameter int A_W   = 2,
    parameter int B_W   = 2,
    parameter int Y_W   = 2,
    parameter int TAG_W = IFT_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [A_W-1:0]   A,
    input  logic [TAG_W-1:0] A_t,
    input  logic [B_W-1:0]   B,
    input  logic [TAG_W-1:0] B_t,
    output logic [Y_W-1:0]   Y,
    output logic [TAG_W-1:0] Y_t
);

    if (A_W < 1 || B_W < 1 || Y_W < 1 || TAG_W < 1) begin : g_bad_width
        $error("shiftx_ift: all widths must be at least 1");
    end

    logic [Y_W-1:0]   y_next;
    logic [TAG_W-1:0] y_t_next;

    ift_shiftx_comb #(
        .A_W   (A_W),
        .B_W   (B_W),
        .Y_W   (Y_W),
        .TAG_W (TAG_W)
    ) u_comb (
        .a   (A),
        .a_t (A_t),
        .b   (B),
        .b_t (B_t),
        .y   (y_next),
        .y_t (y_t_next)
    );

    // Output register; reset clears data and taint at once and wins over a coincident edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y   <= '0;
            Y_t <= '0;
        end else begin
            Y   <= y_next;
            Y_t <= y_t_next;
        end
    end

endmodule

// File: tb/tb_shiftx_ift.sv
// Directed self-checking bench for shiftx_ift with default widths.
module tb_shiftx_ift;

    logic        clk;
    logic        rst_n;
    logic [1:0]  A;
    logic [31:0] A_t;
    logic [1:0]  B;
    logic [31:0] B_t;
    logic [1:0]  Y;
    logic [31:0] Y_t;

    int checks = 0;
    int errors = 0;

    shiftx_ift dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .A_t   (A_t),
        .B     (B),
        .B_t   (B_t),
        .Y     (Y),
        .Y_t   (Y_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand set away from the active edge, then wait until just after it
    task automatic apply_cycle(input logic [1:0] a, input logic [31:0] at,
                               input logic [1:0] b, input logic [31:0] bt);
        @(negedge clk);
        A   = a;
        A_t = at;
        B   = b;
        B_t = bt;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        A = 2'b11; B = 2'b00; A_t = 32'hFFFF_FFFF; B_t = 32'h1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (Y !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_y: got %b expected 00", Y);
        end
        checks++;
        if (Y_t !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_yt: got %h expected 00000000", Y_t);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (Y !== 2'b11) begin
            errors++;
            $display("[TB] FAIL post_reset_y: got %b expected 11", Y);
        end
        checks++;
        if (Y_t !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL post_reset_yt: got %h expected ffffffff", Y_t);
        end
    endtask

    task automatic test_sweep();
        logic [1:0]  exp_y;
        logic [31:0] exp_t;
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                case (bi)
                    0:       begin exp_y = 2'(ai);                 exp_t = 32'h0000_00FF; end
                    1:       begin exp_y = (ai >= 2) ? 2'b01 : 2'b00; exp_t = 32'h0000_00FF; end
                    default: begin exp_y = 2'b00;                  exp_t = 32'h0000_000F; end
                endcase
                apply_cycle(2'(ai), 32'h0000_00F0, 2'(bi), 32'h0000_000F);
                checks++;
                if (Y !== exp_y) begin
                    errors++;
                    $display("[TB] FAIL sweep_y A=%0d B=%0d: got %b expected %b", ai, bi, Y, exp_y);
                end
                checks++;
                if (Y_t !== exp_t) begin
                    errors++;
                    $display("[TB] FAIL sweep_yt A=%0d B=%0d: got %h expected %h", ai, bi, Y_t, exp_t);
                end
            end
        end
    endtask

    task automatic test_a_taint_only();
        apply_cycle(2'b10, 32'h8000_0001, 2'b01, 32'h0);
        checks++;
        if (Y !== 2'b01 || Y_t !== 32'h8000_0001) begin
            errors++;
            $display("[TB] FAIL a_taint_b1: got Y=%b Y_t=%h expected Y=01 Y_t=80000001", Y, Y_t);
        end
        apply_cycle(2'b10, 32'h8000_0001, 2'b10, 32'h0);
        checks++;
        if (Y !== 2'b00 || Y_t !== 32'h0) begin
            errors++;
            $display("[TB] FAIL a_taint_b2: got Y=%b Y_t=%h expected Y=00 Y_t=00000000", Y, Y_t);
        end
    endtask

    task automatic test_b_taint_only();
        for (int k = 0; k < 16; k++) begin
            apply_cycle(2'(k >> 2), 32'h0, 2'(k), 32'h0001_0000);
            checks++;
            if (Y_t !== 32'h0001_0000) begin
                errors++;
                $display("[TB] FAIL b_taint k=%0d: got %h expected 00010000", k, Y_t);
            end
        end
    endtask

    task automatic test_zero_data();
        apply_cycle(2'b00, 32'h5, 2'b00, 32'h0);
        checks++;
        if (Y !== 2'b00 || Y_t !== 32'h5) begin
            errors++;
            $display("[TB] FAIL zero_data: got Y=%b Y_t=%h expected Y=00 Y_t=00000005", Y, Y_t);
        end
    endtask

    task automatic test_async_reset();
        apply_cycle(2'b11, 32'hA5A5_0000, 2'b00, 32'h0000_0003);
        checks++;
        if (Y !== 2'b11 || Y_t !== 32'hA5A5_0003) begin
            errors++;
            $display("[TB] FAIL pre_async: got Y=%b Y_t=%h expected Y=11 Y_t=a5a50003", Y, Y_t);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (clk !== 1'b1 || Y !== 2'b00 || Y_t !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_clear: got Y=%b Y_t=%h clk=%b expected Y=00 Y_t=00000000 clk=1", Y, Y_t, clk);
        end
        @(negedge clk);
        rst_n = 1'b1;
        A = 2'b10; A_t = 32'h0000_0100; B = 2'b01; B_t = 32'h0000_0010;
        @(posedge clk);
        #1;
        checks++;
        if (Y !== 2'b01 || Y_t !== 32'h0000_0110) begin
            errors++;
            $display("[TB] FAIL first_after_reset: got Y=%b Y_t=%h expected Y=01 Y_t=00000110", Y, Y_t);
        end
    endtask

    task automatic test_back_to_back();
        apply_cycle(2'b11, 32'h1, 2'b01, 32'h2);
        checks++;
        if (Y !== 2'b01 || Y_t !== 32'h3) begin
            errors++;
            $display("[TB] FAIL b2b_0: got Y=%b Y_t=%h expected Y=01 Y_t=00000003", Y, Y_t);
        end
        apply_cycle(2'b01, 32'h4, 2'b11, 32'h8);
        checks++;
        if (Y !== 2'b00 || Y_t !== 32'h8) begin
            errors++;
            $display("[TB] FAIL b2b_1: got Y=%b Y_t=%h expected Y=00 Y_t=00000008", Y, Y_t);
        end
        apply_cycle(2'b10, 32'h10, 2'b00, 32'h20);
        checks++;
        if (Y !== 2'b10 || Y_t !== 32'h30) begin
            errors++;
            $display("[TB] FAIL b2b_2: got Y=%b Y_t=%h expected Y=10 Y_t=00000030", Y, Y_t);
        end
    endtask

    // Scenario sequence, then the single summary line
    initial begin
        rst_n = 1'b0;
        A = '0; A_t = '0; B = '0; B_t = '0;
        test_reset();
        test_sweep();
        test_a_taint_only();
        test_b_taint_only();
        test_zero_data();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion before 100000");
        $fatal(1, "[TB] timeout");
    end

endmodule
